// File: rtl/riscv_alu.sv
// 32-bit RISC-V execute-stage ALU: combinational result/flags plus a registered
// copy of result/zero and a sticky flag for undefined opcodes.
module riscv_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  alu_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow,
    output logic        carry,
    output logic [31:0] result_q,
    output logic        zero_q,
    output logic        illegal_op
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

    logic [32:0] sum_ext;
    logic [32:0] diff_ext;
    logic [4:0]  shamt;
    logic        op_legal;

    assign sum_ext  = {1'b0, in_a} + {1'b0, in_b};
    // Bit 32 of the extended difference is the borrow; carry reports its inverse.
    assign diff_ext = {1'b0, in_a} - {1'b0, in_b};
    assign shamt    = in_b[4:0];
    assign op_legal = (alu_op <= OP_SRA);

    always_comb begin
        result   = 32'd0;
        overflow = 1'b0;
        carry    = 1'b0;
        case (alu_op)
            OP_AND:  result = in_a & in_b;
            OP_OR:   result = in_a | in_b;
            OP_ADD: begin
                result   = sum_ext[31:0];
                carry    = sum_ext[32];
                overflow = (in_a[31] == in_b[31]) && (sum_ext[31] != in_a[31]);
            end
            OP_XOR:  result = in_a ^ in_b;
            OP_SLL:  result = in_a << shamt;
            OP_SRL:  result = in_a >> shamt;
            OP_SUB: begin
                result   = diff_ext[31:0];
                carry    = ~diff_ext[32];
                overflow = (in_a[31] != in_b[31]) && (diff_ext[31] != in_a[31]);
            end
            OP_SLT:  result = {31'd0, $signed(in_a) < $signed(in_b)};
            OP_SLTU: result = {31'd0, in_a < in_b};
            OP_SRA:  result = $unsigned($signed(in_a) >>> shamt);
            default: result = 32'd0;
        endcase
    end

    assign zero = ~|result;

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q   <= 32'd0;
            zero_q     <= 1'b1;
            illegal_op <= 1'b0;
        end else begin
            result_q <= result;
            zero_q   <= zero;
            if (!op_legal) begin
                illegal_op <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_alu.sv
// Directed self-checking bench for riscv_alu: hand-computed vectors checked with
// immediate assertions, including the registered path and the sticky illegal flag.
module tb_riscv_alu;

    logic        clk;
    logic        rst;
    logic [3:0]  alu_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        carry;
    logic [31:0] result_q;
    logic        zero_q;
    logic        illegal_op;

    int n_cmp;
    int n_bad;

    riscv_alu dut (
        .clk        (clk),
        .rst        (rst),
        .alu_op     (alu_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .result     (result),
        .zero       (zero),
        .overflow   (overflow),
        .carry      (carry),
        .result_q   (result_q),
        .zero_q     (zero_q),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_op = op;
        in_a   = a;
        in_b   = b;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] r, input logic z,
                             input logic ov, input logic cy);
        check({tag, " result"}, result, r);
        check({tag, " zero"}, {31'd0, zero}, {31'd0, z});
        check({tag, " overflow"}, {31'd0, overflow}, {31'd0, ov});
        check({tag, " carry"}, {31'd0, carry}, {31'd0, cy});
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        alu_op = 4'b0000;
        in_a   = 32'd0;
        in_b   = 32'd0;

        // Reset state
        tick();
        check("rst result_q", result_q, 32'd0);
        check("rst zero_q", {31'd0, zero_q}, 32'd1);
        check("rst illegal_op", {31'd0, illegal_op}, 32'd0);

        // Registered path: combinational immediately, registered one edge later
        rst = 1'b0;
        apply(4'b0010, 32'd5, 32'd6);
        check("add comb now", result, 32'd11);
        check("add result_q before edge", result_q, 32'd0);
        tick();
        check("add result_q", result_q, 32'd11);
        check("add zero_q", {31'd0, zero_q}, 32'd0);

        // Reset mid-stream leaves combinational outputs alone
        rst = 1'b1;
        #1;
        check("rst comb result", result, 32'd11);
        tick();
        check("rst2 result_q", result_q, 32'd0);
        check("rst2 zero_q", {31'd0, zero_q}, 32'd1);
        rst = 1'b0;

        // Logic ops
        apply(4'b0000, 32'hffffffff, 32'h00ff00ff);
        check_all("and", 32'h00ff00ff, 1'b0, 1'b0, 1'b0);
        apply(4'b0001, 32'h0f0f0f0f, 32'hffff0000);
        check_all("or", 32'hffff0f0f, 1'b0, 1'b0, 1'b0);
        apply(4'b0001, 32'd0, 32'd0);
        check_all("or zero", 32'd0, 1'b1, 1'b0, 1'b0);
        apply(4'b0011, 32'hf0f0a5a5, 32'h0ff0ffff);
        check_all("xor", 32'hff005a5a, 1'b0, 1'b0, 1'b0);

        // ADD
        apply(4'b0010, 32'hffffffff, 32'd1);
        check_all("add wrap", 32'd0, 1'b1, 1'b0, 1'b1);
        apply(4'b0010, 32'hffffffff, 32'd400);
        check_all("add m1+400", 32'd399, 1'b0, 1'b0, 1'b1);
        apply(4'b0010, 32'hffffffff, 32'hffffffff);
        check_all("add m1+m1", 32'hfffffffe, 1'b0, 1'b0, 1'b1);
        apply(4'b0010, 32'h80000000, 32'h80000000);
        check_all("add ovf", 32'd0, 1'b1, 1'b1, 1'b1);
        apply(4'b0010, 32'h7fffffff, 32'd1);
        check_all("add pos ovf", 32'h80000000, 1'b0, 1'b1, 1'b0);

        // SUB
        apply(4'b0110, 32'd5, 32'd6);
        check_all("sub 5-6", 32'hffffffff, 1'b0, 1'b0, 1'b0);
        apply(4'b0110, -32'sd15, -32'sd9);
        check_all("sub -15--9", 32'hfffffffa, 1'b0, 1'b0, 1'b0);
        apply(4'b0110, -32'sd53512, -32'sd53513);
        check_all("sub neg", 32'd1, 1'b0, 1'b0, 1'b1);
        apply(4'b0110, 32'd0, 32'd500);
        check_all("sub 0-500", 32'hfffffe0c, 1'b0, 1'b0, 1'b0);
        apply(4'b0110, 32'h80000000, 32'd1);
        check_all("sub min-1", 32'h7fffffff, 1'b0, 1'b1, 1'b1);
        apply(4'b0110, 32'h7fffffff, 32'hffffffff);
        check_all("sub max-m1", 32'h80000000, 1'b0, 1'b1, 1'b0);
        apply(4'b0110, 32'd555121, 32'd555121);
        check_all("sub equal", 32'd0, 1'b1, 1'b0, 1'b1);

        // Shifts and compares
        apply(4'b1001, 32'h80000000, 32'd4);
        check_all("sra", 32'hf8000000, 1'b0, 1'b0, 1'b0);
        apply(4'b0101, 32'h80000000, 32'd4);
        check_all("srl", 32'h08000000, 1'b0, 1'b0, 1'b0);
        apply(4'b0101, 32'h80000000, 32'hffffffe4);
        check("srl upper bits ignored", result, 32'h08000000);
        apply(4'b0100, 32'h00000003, 32'd31);
        check("sll 31", result, 32'h80000000);
        apply(4'b0100, 32'h00000001, 32'h00000024);
        check("sll upper bits ignored", result, 32'h00000010);
        apply(4'b0111, 32'hffffffff, 32'd1);
        check_all("slt", 32'd1, 1'b0, 1'b0, 1'b0);
        apply(4'b1000, 32'hffffffff, 32'd1);
        check_all("sltu", 32'd0, 1'b1, 1'b0, 1'b0);
        apply(4'b1000, 32'd1, 32'hffffffff);
        check("sltu true", result, 32'd1);

        // Undefined opcode: comb zero, sticky flag from next edge
        check("illegal before", {31'd0, illegal_op}, 32'd0);
        apply(4'b1110, 32'd5, 32'd2222);
        check_all("undef", 32'd0, 1'b1, 1'b0, 1'b0);
        apply(4'b1010, 32'hffffffff, 32'hffffffff);
        check_all("undef 1010", 32'd0, 1'b1, 1'b0, 1'b0);
        apply(4'b1110, 32'd5, 32'd2222);
        tick();
        check("illegal set", {31'd0, illegal_op}, 32'd1);
        check("undef result_q", result_q, 32'd0);
        check("undef zero_q", {31'd0, zero_q}, 32'd1);
        apply(4'b0010, 32'd5, 32'd6);
        tick();
        tick();
        check("illegal sticky", {31'd0, illegal_op}, 32'd1);
        rst = 1'b1;
        tick();
        check("illegal cleared", {31'd0, illegal_op}, 32'd0);

        // Reset coinciding with an illegal opcode wins
        apply(4'b1111, 32'd1, 32'd1);
        tick();
        check("rst beats illegal", {31'd0, illegal_op}, 32'd0);
        rst = 1'b0;
        tick();
        check("illegal after rst release", {31'd0, illegal_op}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
